mem_access_ctrl: RTL and testbench

Single-port initiator that issues word loads and stores to one port of the team's dual-port synchronous RAM on behalf of the datapath. Requests arrive over a valid/ready handshake. The block drives registered address, data and write-enable to the RAM and absorbs its one-cycle read latency. Read data returns over a valid/ready response channel with backpressure. It sits between the CPU load/store path and RAM port A; port B stays free for the VGA/IO side.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the RAM port-A access controller.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RSP     = 3'd4
    } state_e;

    localparam int RAM_RD_LATENCY = 1;

    // The top address bit selects the bank; only the lower bank is populated.
    function automatic int bank_sel_bit(input int addr_width);
        return addr_width - 1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the load/store path and mem_access_ctrl.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port load/store initiator for RAM port A; absorbs the one-cycle read latency.
// Optional MEM_BANK_CHECK_EN blocks accesses to the unpopulated upper bank and flags bank_err.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WRITE   | ram_we high for this single cycle
// RD_ADDR | RAM samples ram_addr at the end of this cycle
// RD_CAP  | ram_q valid, captured into rsp_rdata
// RSP     | rsp_valid high until rsp_ready
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  bank_err
);

    localparam int BANK_BIT = bank_sel_bit(ADDR_WIDTH);

    state_e                state_q,     state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  wr_q,        wr_d;
    logic                  bad_q,       bad_d;
    logic                  bank_err_q,  bank_err_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q,  ram_data_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic bad_bank;

    assign accept = bus.req_valid && req_ready_q;

`ifdef MEM_BANK_CHECK_EN
    assign bad_bank = bus.req_addr[BANK_BIT];
`else
    assign bad_bank = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        wr_d        = 1'b0;
        bad_d       = bad_q;
        bank_err_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    bad_d       = bad_bank;
                    bank_err_d  = bad_bank;
                    req_ready_d = 1'b0;
                    // A blocked access leaves the RAM-facing registers untouched.
                    if (!bad_bank) begin
                        ram_addr_d = bus.req_addr;
                        ram_data_d = bus.req_wdata;
                    end
                    if (bus.req_we) begin
                        wr_d    = !bad_bank;
                        state_d = WRITE;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WRITE: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rsp_rdata_d = bad_q ? '0 : ram_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            bank_err_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_q        <= wr_d;
            bad_q       <= bad_d;
            bank_err_q  <= bank_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign ram_we        = wr_q;
    assign bank_err      = bank_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl with a word-array reference model and RAM stub.
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          ram_we;
    logic          bank_err;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .bank_err (bank_err)
    );

    // Synchronous RAM stub with a bench-side preload path.
    logic [DW-1:0] tb_mem [0:1023];
    logic          init_en   = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [DW-1:0] init_data = '0;

    always @(posedge clk) begin
        if (init_en)     tb_mem[init_addr] <= init_data;
        else if (ram_we) tb_mem[ram_addr]  <= ram_data;
        ram_q <= tb_mem[ram_addr];
    end

    int we_cnt = 0;
    int be_cnt = 0;
    always @(posedge clk) begin
        if (ram_we === 1'b1)   we_cnt <= we_cnt + 1;
        if (bank_err === 1'b1) be_cnt <= be_cnt + 1;
    end

    logic [DW-1:0] ref_mem [0:1023];
    logic [AW-1:0] exp_addr;
    int checks = 0;
    int errors = 0;

    function automatic bit is_bad(input logic [AW-1:0] a);
`ifdef MEM_BANK_CHECK_EN
        return a[AW-1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit bad;
        int w0;
        bad = is_bad(a);
        w0  = we_cnt;
        chk("st_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        if (!bad) exp_addr = a;
        chk("st_ram_we",   32'(ram_we),        32'(!bad));
        chk("st_ram_addr", 32'(ram_addr),      32'(exp_addr));
        chk("st_bank_err", 32'(bank_err),      32'(bad));
        chk("st_busy",     32'(bus.req_ready), 32'd0);
        if (!bad) chk("st_ram_data", 32'(ram_data), 32'(d));
        tick();
        chk("st_we_drop",     32'(ram_we),        32'd0);
        chk("st_ready_back",  32'(bus.req_ready), 32'd1);
        chk("st_be_drop",     32'(bank_err),      32'd0);
        chk("st_we_count",    32'(we_cnt - w0),   bad ? 32'd0 : 32'd1);
        if (!bad) ref_mem[a] = d;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input int hold);
        bit bad;
        logic [DW-1:0] exp_rd;
        bad    = is_bad(a);
        exp_rd = bad ? '0 : ref_mem[a];
        chk("ld_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.rsp_ready = (hold == 0);
        tick();
        bus.req_valid = 1'b0;
        if (!bad) exp_addr = a;
        chk("ld_ram_addr", 32'(ram_addr),      32'(exp_addr));
        chk("ld_bank_err", 32'(bank_err),      32'(bad));
        chk("ld_busy",     32'(bus.req_ready), 32'd0);
        chk("ld_no_we",    32'(ram_we),        32'd0);
        chk("ld_e0_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("ld_e1_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("ld_e2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ld_rdata",    32'(bus.rsp_rdata), 32'(exp_rd));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("ld_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("ld_hold_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
            chk("ld_hold_busy",  32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("ld_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("ld_done_ready", 32'(bus.req_ready), 32'd1);
        chk("ld_rdata_held", 32'(bus.rsp_rdata), 32'(exp_rd));
    endtask

    initial begin
        int b0;
        int w0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        exp_addr      = '0;

        // Preload RAM and the model while the DUT is held in reset.
        init_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            init_addr  = AW'(i);
            init_data  = (i == 16) ? 16'hBEEF : 16'h0000;
            ref_mem[i] = init_data;
            tick();
        end
        init_en = 1'b0;

        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_ram_we",    32'(ram_we),        32'd0);
        chk("rst_ram_addr",  32'(ram_addr),      32'd0);
        chk("rst_ram_data",  32'(ram_data),      32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_bank_err",  32'(bank_err),      32'd0);
        rst_n = 1'b1;
        tick();

        // Store then load the same word.
        do_store(10'h005, 16'h1234);
        do_load(10'h005, 0);

        // Preloaded word with consumer backpressure.
        do_load(10'h010, 4);

        // Back-to-back stores with req_valid held high.
        w0 = we_cnt;
        d  = DW'($urandom);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = d;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", 32'(bus.req_ready), 32'd1);
            tick();
            chk("b2b_we",   32'(ram_we),   32'd1);
            chk("b2b_addr", 32'(ram_addr), 32'(i));
            chk("b2b_data", 32'(ram_data), 32'(d));
            ref_mem[i] = d;
            exp_addr   = AW'(i);
            if (i < 7) begin
                d             = DW'($urandom);
                bus.req_addr  = AW'(i + 1);
                bus.req_wdata = d;
            end else begin
                bus.req_valid = 1'b0;
                bus.req_we    = 1'b0;
            end
            tick();
            chk("b2b_we_low", 32'(ram_we), 32'd0);
        end
        chk("b2b_we_count", 32'(we_cnt - w0), 32'd8);
        for (int i = 0; i < 8; i++) chk("b2b_ram_content", 32'(tb_mem[i]), 32'(ref_mem[i]));
        do_load(10'h003, 1);

        // Upper-bank access.
        b0 = be_cnt;
        do_store(10'h205, 16'hAAAA);
        do_load(10'h205, 0);
`ifdef MEM_BANK_CHECK_EN
        chk("bank_err_pulses", 32'(be_cnt - b0), 32'd2);
`else
        chk("bank_err_pulses", 32'(be_cnt - b0), 32'd0);
`endif

        // Randomized mix of loads and stores, biased toward a small hot region.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 1023));
            else                           a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_store(a, DW'($urandom));
            else                           do_load(a, int'($urandom_range(0, 2)));
        end

        // Reset while a response is pending.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h005;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("rsp_before_rst", 32'(bus.rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_async",  32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_ready",  32'(bus.req_ready), 32'd1);
        tick();
        rst_n    = 1'b1;
        exp_addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
            chk("post_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
            chk("post_rst_addr",  32'(ram_addr),      32'd0);
        end

        // Reset during the write cycle: the stub only writes on a sampled ram_we.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'h007;
        bus.req_wdata = 16'h5555;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        chk("wr_before_rst", 32'(ram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_async", 32'(ram_we), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_wr_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_wr_rst_we",    32'(ram_we),        32'd0);
        chk("post_wr_rst_mem",   32'(tb_mem[7]),     32'(ref_mem[7]));

        do_store(10'h00A, 16'hC0DE);
        do_load(10'h00A, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
